// File: rtl/instr_mem_ctrl.sv
// Instruction RAM: answers fetches one cycle after ird_i and accepts loader words while the core is held in reset.
// The loader is backpressured by ld_ready_o, which is high only in LOAD. Fetches cannot be stalled.
module instr_mem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           iaddr_i,
  input  logic                  ird_i,
  output logic [31:0]           irdata_o,
  output logic                  fetch_fault_o,
  output logic [31:0]           fault_addr_o,
  input  logic                  ld_start_i,
  input  logic [DEPTH_LOG2:0]   ld_count_i,
  input  logic                  ld_valid_i,
  input  logic [31:0]           ld_data_i,
  output logic                  ld_ready_o,
  output logic                  ld_done_o,
  input  logic                  run_i,
  input  logic                  halt_i,
  output logic                  core_reset_o
);

  localparam int unsigned          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_RUN
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    r_fault_seen;

  logic [31:0]             w_diff;
  logic                    w_hit;
  logic [DEPTH_LOG2-1:0]   w_rd_idx;
  logic                    w_ld_fire;
  logic [DEPTH_LOG2:0]     w_ptr_inc;
  logic [DEPTH_LOG2:0]     w_count_eff;
  logic                    w_last;

  // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign w_diff      = iaddr_i - BASE_ADDR;
  assign w_hit       = (w_diff[1:0] == 2'b00) && (w_diff[31:DEPTH_LOG2+2] == '0);
  assign w_rd_idx    = w_diff[DEPTH_LOG2+1:2];
  assign w_ld_fire   = (r_state == S_LOAD) && ld_ready_o && ld_valid_i;
  assign w_ptr_inc   = {1'b0, r_wr_ptr} + {{DEPTH_LOG2{1'b0}}, 1'b1};
  assign w_count_eff = (r_count == '0) ? FULL_COUNT : r_count;
  assign w_last      = (w_ptr_inc == w_count_eff);

  // RAM contents survive reset so a partial load is not lost.
  always_ff @(posedge clk_i) begin
    if (w_ld_fire) begin
      r_mem[r_wr_ptr] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fault_seen  <= 1'b0;
      irdata_o      <= NOP_WORD;
      fetch_fault_o <= 1'b0;
      fault_addr_o  <= '0;
      ld_ready_o    <= 1'b0;
      ld_done_o     <= 1'b0;
      core_reset_o  <= 1'b1;
    end else begin
      ld_done_o     <= 1'b0;
      fetch_fault_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          irdata_o <= NOP_WORD;
          if (ld_start_i) begin
            r_state    <= S_LOAD;
            r_count    <= ld_count_i;
            r_wr_ptr   <= '0;
            ld_ready_o <= 1'b1;
          end else if (run_i) begin
            r_state      <= S_RUN;
            core_reset_o <= 1'b0;
          end
        end
        S_LOAD: begin
          irdata_o <= NOP_WORD;
          if (w_ld_fire) begin
            r_wr_ptr <= w_ptr_inc[DEPTH_LOG2-1:0];
            if (w_last) begin
              r_state    <= S_DONE;
              ld_ready_o <= 1'b0;
              ld_done_o  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          irdata_o <= NOP_WORD;
          r_state  <= S_IDLE;
        end
        S_RUN: begin
          if (halt_i) begin
            r_state      <= S_IDLE;
            core_reset_o <= 1'b1;
            irdata_o     <= NOP_WORD;
          end else if (ird_i) begin
            if (w_hit) begin
              irdata_o <= r_mem[w_rd_idx];
            end else begin
              irdata_o      <= NOP_WORD;
              fetch_fault_o <= 1'b1;
              if (!r_fault_seen) begin
                fault_addr_o <= iaddr_i;
                r_fault_seen <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: load, fetch, faults, reset mid-load, start/run priority, halt, full-depth load.
module tb_instr_mem_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] iaddr_i;
  logic        ird_i;
  logic [31:0] irdata_o;
  logic        fetch_fault_o;
  logic [31:0] fault_addr_o;
  logic        ld_start_i;
  logic [10:0] ld_count_i;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        run_i;
  logic        halt_i;
  logic        core_reset_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] prog [4];

  instr_mem_ctrl dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .iaddr_i       (iaddr_i),
    .ird_i         (ird_i),
    .irdata_o      (irdata_o),
    .fetch_fault_o (fetch_fault_o),
    .fault_addr_o  (fault_addr_o),
    .ld_start_i    (ld_start_i),
    .ld_count_i    (ld_count_i),
    .ld_valid_i    (ld_valid_i),
    .ld_data_i     (ld_data_i),
    .ld_ready_o    (ld_ready_o),
    .ld_done_o     (ld_done_o),
    .run_i         (run_i),
    .halt_i        (halt_i),
    .core_reset_o  (core_reset_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; iaddr_i = '0; ird_i = 1'b0; ld_start_i = 1'b0; ld_count_i = '0;
    ld_valid_i = 1'b0; ld_data_i = '0; run_i = 1'b0; halt_i = 1'b0;
    tick(); tick();
    n_cmp++; if (irdata_o !== NOP) begin n_err++; $display("FAIL rst_irdata: got %h want %h", irdata_o, NOP); end
    n_cmp++; if (fetch_fault_o !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fetch_fault_o); end
    n_cmp++; if (fault_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_fault_addr: got %h want 0", fault_addr_o); end
    n_cmp++; if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ld_ready_o); end
    n_cmp++; if (ld_done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", ld_done_o); end
    n_cmp++; if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL rst_core_reset: got %b want 1", core_reset_o); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_load_gap();
    int idx = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;
    bit core_rel = 1'b0;
    ld_start_i = 1'b1; ld_count_i = 11'd4;
    tick();
    ld_start_i = 1'b0;
    for (int step = 0; step < 10; step++) begin
      if (ld_ready_o) rdy_cnt++;
      if (ld_done_o) done_cnt++;
      if (core_reset_o !== 1'b1) core_rel = 1'b1;
      if (ld_ready_o && idx < 4 && step != 2) begin
        ld_valid_i = 1'b1; ld_data_i = prog[idx]; idx++;
      end else begin
        ld_valid_i = 1'b0;
      end
      tick();
    end
    n_cmp++; if (rdy_cnt != 5) begin n_err++; $display("FAIL load_ready_cycles: got %0d want 5", rdy_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL load_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (core_rel !== 1'b0) begin n_err++; $display("FAIL load_core_reset: core_reset dropped during load, want held 1"); end
    n_cmp++; if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL load_idle_ready: got %b want 0", ld_ready_o); end
  endtask

  task automatic test_fetch();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    n_cmp++; if (core_reset_o !== 1'b0) begin n_err++; $display("FAIL run_core_reset: got %b want 0", core_reset_o); end
    for (int i = 0; i < 4; i++) begin
      ird_i = 1'b1; iaddr_i = 32'(i * 4);
      tick();
      n_cmp++; if (irdata_o !== prog[i]) begin n_err++; $display("FAIL fetch_word%0d: got %h want %h", i, irdata_o, prog[i]); end
      n_cmp++; if (fetch_fault_o !== 1'b0) begin n_err++; $display("FAIL fetch_nofault%0d: got %b want 0", i, fetch_fault_o); end
    end
    ird_i = 1'b0; iaddr_i = 32'h0;
    tick();
    n_cmp++; if (irdata_o !== prog[3]) begin n_err++; $display("FAIL fetch_hold: got %h want %h", irdata_o, prog[3]); end
  endtask

  task automatic test_fault();
    ird_i = 1'b1; iaddr_i = 32'h0000_0002;
    tick();
    n_cmp++; if (fetch_fault_o !== 1'b1) begin n_err++; $display("FAIL fault_misal_pulse: got %b want 1", fetch_fault_o); end
    n_cmp++; if (irdata_o !== NOP) begin n_err++; $display("FAIL fault_misal_data: got %h want %h", irdata_o, NOP); end
    n_cmp++; if (fault_addr_o !== 32'h2) begin n_err++; $display("FAIL fault_misal_addr: got %h want 2", fault_addr_o); end
    iaddr_i = 32'h0000_1000;
    tick();
    n_cmp++; if (fetch_fault_o !== 1'b1) begin n_err++; $display("FAIL fault_range_pulse: got %b want 1", fetch_fault_o); end
    n_cmp++; if (irdata_o !== NOP) begin n_err++; $display("FAIL fault_range_data: got %h want %h", irdata_o, NOP); end
    n_cmp++; if (fault_addr_o !== 32'h2) begin n_err++; $display("FAIL fault_sticky: got %h want 2", fault_addr_o); end
    iaddr_i = 32'h0000_0004;
    tick();
    n_cmp++; if (fetch_fault_o !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %b want 0", fetch_fault_o); end
    n_cmp++; if (irdata_o !== prog[1]) begin n_err++; $display("FAIL fault_recover: got %h want %h", irdata_o, prog[1]); end
    ird_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int done_cnt = 0;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hAAAA_0001; exp_w[1] = 32'hBBBB_0002; exp_w[2] = prog[2];
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0; ld_start_i = 1'b1; ld_count_i = 11'd4;
    tick();
    ld_start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = exp_w[0];
    tick();
    ld_data_i = exp_w[1];
    tick();
    ld_valid_i = 1'b0; reset_i = 1'b1;
    #1;
    n_cmp++; if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", ld_ready_o); end
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ld_done_o) done_cnt++;
      tick();
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (fault_addr_o !== 32'h0) begin n_err++; $display("FAIL abort_fault_addr: got %h want 0", fault_addr_o); end
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ird_i = 1'b1; iaddr_i = 32'(i * 4);
      tick();
      n_cmp++; if (irdata_o !== exp_w[i]) begin n_err++; $display("FAIL abort_word%0d: got %h want %h", i, irdata_o, exp_w[i]); end
    end
    ird_i = 1'b0;
    tick();
  endtask

  task automatic test_start_run_halt();
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0; ld_start_i = 1'b1; run_i = 1'b1; ld_count_i = 11'd1;
    tick();
    ld_start_i = 1'b0;
    n_cmp++; if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL prio_ready: got %b want 1", ld_ready_o); end
    n_cmp++; if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL prio_core_reset: got %b want 1", core_reset_o); end
    tick();
    n_cmp++; if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL prio_run_ignored: got %b want 1", ld_ready_o); end
    run_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = 32'h1234_5678;
    tick();
    ld_valid_i = 1'b0;
    n_cmp++; if (ld_done_o !== 1'b1) begin n_err++; $display("FAIL prio_done: got %b want 1", ld_done_o); end
    n_cmp++; if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL prio_ready_drop: got %b want 0", ld_ready_o); end
    tick();
    n_cmp++; if (ld_done_o !== 1'b0) begin n_err++; $display("FAIL prio_done_once: got %b want 0", ld_done_o); end
    run_i = 1'b1;
    tick();
    run_i = 1'b0; ird_i = 1'b1; iaddr_i = 32'h0;
    tick();
    n_cmp++; if (irdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL prio_fetch: got %h want 12345678", irdata_o); end
    halt_i = 1'b1; iaddr_i = 32'h4;
    tick();
    halt_i = 1'b0; ird_i = 1'b0;
    n_cmp++; if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL halt_core_reset: got %b want 1", core_reset_o); end
    n_cmp++; if (irdata_o !== NOP) begin n_err++; $display("FAIL halt_irdata: got %h want %h", irdata_o, NOP); end
    n_cmp++; if (fetch_fault_o !== 1'b0) begin n_err++; $display("FAIL halt_fault: got %b want 0", fetch_fault_o); end
  endtask

  task automatic test_full_load();
    int acc = 0;
    bit seen_done = 1'b0;
    ld_start_i = 1'b1; ld_count_i = 11'd0;
    tick();
    ld_start_i = 1'b0; ld_valid_i = 1'b1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (ld_done_o) begin
        seen_done = 1'b1;
        break;
      end
      if (ld_ready_o) begin
        ld_data_i = 32'hC000_0000 + 32'(acc);
        acc++;
      end
      tick();
    end
    ld_valid_i = 1'b0;
    n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL full_done: no done pulse within 1200 cycles"); end
    n_cmp++; if (acc != 1024) begin n_err++; $display("FAIL full_count: got %0d transfers want 1024", acc); end
    tick();
    run_i = 1'b1;
    tick();
    run_i = 1'b0; ird_i = 1'b1; iaddr_i = 32'h0000_0FFC;
    tick();
    n_cmp++; if (irdata_o !== 32'hC000_03FF) begin n_err++; $display("FAIL full_last: got %h want c00003ff", irdata_o); end
    iaddr_i = 32'h0000_0000;
    tick();
    n_cmp++; if (irdata_o !== 32'hC000_0000) begin n_err++; $display("FAIL full_first: got %h want c0000000", irdata_o); end
    iaddr_i = 32'h0000_0800;
    tick();
    n_cmp++; if (irdata_o !== 32'hC000_0200) begin n_err++; $display("FAIL full_mid: got %h want c0000200", irdata_o); end
    iaddr_i = 32'h0000_1000;
    tick();
    n_cmp++; if (fetch_fault_o !== 1'b1) begin n_err++; $display("FAIL full_oob_pulse: got %b want 1", fetch_fault_o); end
    n_cmp++; if (fault_addr_o !== 32'h0000_1000) begin n_err++; $display("FAIL full_oob_addr: got %h want 00001000", fault_addr_o); end
    iaddr_i = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (fetch_fault_o !== 1'b1) begin n_err++; $display("FAIL wrap_pulse: got %b want 1", fetch_fault_o); end
    n_cmp++; if (fault_addr_o !== 32'h0000_1000) begin n_err++; $display("FAIL wrap_sticky: got %h want 00001000", fault_addr_o); end
    ird_i = 1'b0;
    tick();
  endtask

  initial begin
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_8113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_006F;
    test_reset();
    test_load_gap();
    test_fetch();
    test_fault();
    test_reset_mid_load();
    test_start_run_halt();
    test_full_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
